// File: rtl/polar_enc_iter.sv
// Iterative N-point polar encoder: loads a K-bit message onto the information set
// and applies one in-place butterfly stage per clock, presenting x = u*F^{(x)n}.
module polar_enc_iter #(
   parameter int             N           = 16,
   parameter int             LOG2N       = 4,
   parameter int             K           = 8,
   parameter logic [N-1:0]   FROZEN_MASK = 16'h017F
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           msg_valid,
   output logic           msg_ready,
   input  logic [K-1:0]   msg,
   output logic           cw_valid,
   input  logic           cw_ready,
   output logic [N-1:0]   cw,
   output logic           busy
);

   function automatic int info_count();
      int c = 0;
      for (int p = 0; p < N; p++) if (!FROZEN_MASK[p]) c++;
      return c;
   endfunction

   // Message bit index that lands on position p: number of info positions below p.
   function automatic int info_rank(int p);
      int c = 0;
      for (int q = 0; q < p; q++) if (!FROZEN_MASK[q]) c++;
      return c;
   endfunction

   generate
      if (K != info_count()) begin : g_k_check
         $error("polar_enc_iter: K does not match the number of non-frozen positions");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

   state_t             state;
   logic [N-1:0]       u_q;
   logic [N-1:0]       u_load;
   logic [N-1:0]       bfly;
   logic [N-1:0]       cw_q;
   logic [LOG2N-1:0]   stage;
   logic [N-1:0]       stage_x [LOG2N];
   logic               last_stage;

   for (genvar p = 0; p < N; p++) begin : g_load
      if (FROZEN_MASK[p]) begin : g_frz
         assign u_load[p] = 1'b0;
      end else begin : g_info
         localparam int R = info_rank(p);
         assign u_load[p] = msg[R];
      end
   end

   // Each stage pairs (lo, lo + 2^s) where lo has bit s clear; hi passes through.
   for (genvar s = 0; s < LOG2N; s++) begin : g_stage
      logic [N-1:0] x;
      for (genvar i = 0; i < N/2; i++) begin : g_pair
         localparam int LO = ((i >> s) << (s + 1)) | (i & ((1 << s) - 1));
         localparam int HI = LO + (1 << s);
         assign x[LO] = u_q[LO] ^ u_q[HI];
         assign x[HI] = u_q[HI];
      end
      assign stage_x[s] = x;
   end

   always_comb begin
      bfly = u_q;
      for (int s = 0; s < LOG2N; s++)
         if (stage == LOG2N'(s)) bfly = stage_x[s];
   end

   assign last_stage = (stage == LOG2N'(LOG2N - 1));
   assign msg_ready  = !rst && ((state == IDLE) || ((state == DONE) && cw_ready));
   assign cw         = cw_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         u_q      <= '0;
         stage    <= '0;
         cw_q     <= '0;
         cw_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (msg_valid) begin
                  u_q   <= u_load;
                  stage <= '0;
                  busy  <= 1'b1;
                  state <= ENC;
               end
            end
            ENC: begin
               u_q <= bfly;
               if (last_stage) begin
                  stage    <= '0;
                  cw_q     <= bfly;
                  cw_valid <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end else begin
                  stage <= stage + 1'b1;
               end
            end
            DONE: begin
               if (cw_ready) begin
                  cw_valid <= 1'b0;
                  if (msg_valid) begin
                     u_q   <= u_load;
                     stage <= '0;
                     busy  <= 1'b1;
                     state <= ENC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/polar_enc_iter.md
Name: polar_enc_iter

Overview:
- Iterative polar encoder; the transmit-side counterpart of the decoder special-node units. Same N=16 frame size and natural (non-bit-reversed) index order as the decoder process unit.
- Accepts a K-bit message and places it on the non-frozen positions of u; frozen positions are forced to 0.
- Computes x = u·F^{⊗n} in place, one butterfly stage per clock.
- Presents the N-bit codeword on a valid/ready output.

Parameters:
- N, 16, codeword length; power of two.
- LOG2N, 4, log2(N); number of butterfly stages.
- K, 8, message length; must equal N minus popcount(FROZEN_MASK). Mismatch is an elaboration error.
- FROZEN_MASK, 16'h017F, bit i=1 means u[i] is frozen (0). Default info set is {7,9,10,11,12,13,14,15}.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- msg_valid  in  1  message present.
- msg_ready  out  1  encoder can accept a message this cycle.
- msg  in  K  message bits; msg[0] maps to the lowest non-frozen index.
- cw_valid  out  1  codeword valid.
- cw_ready  in  1  downstream accepts the codeword.
- cw  out  N  codeword; cw[j] = x_j.
- busy  out  1  high in ENC state.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, u register=0, stage counter=0, cw=0, cw_valid=0, busy=0.
  - msg_ready is 0 while rst is high.
  - Reset overrides any operation in flight; the partial codeword is discarded and no cw_valid is emitted.
- FSM states:
  - IDLE: msg_ready=1. On msg_valid=1, load u and go to ENC with stage=0.
  - ENC: msg_ready=0, busy=1. At each edge, apply stage s=stage: for every i with bit s of i equal to 0, u[i] <= u[i] ^ u[i+2^s]; u[i+2^s] is unchanged. stage increments each edge. After the edge that applies s=LOG2N-1, go to DONE.
  - DONE: cw_valid=1, cw=u, held stable until cw_ready=1. msg_ready = cw_ready (combinational).
    - cw_ready=1 and msg_valid=0: go to IDLE.
    - cw_ready=1 and msg_valid=1: back-to-back; load the new message and go to ENC with stage=0, no IDLE bubble.
- Load rule: u[p] = msg[k] where p is the k-th (0-based, ascending) index with FROZEN_MASK[p]=0. All frozen u[p] = 0. This mapping is built at elaboration with a generate/function; it is not a runtime search.
- Latency: the accept edge is e0. Stages are applied at edges e1..eLOG2N. cw_valid is high in the cycle after edge e(LOG2N), i.e. LOG2N cycles after the accept cycle (4 at the defaults).
- Throughput: one codeword per LOG2N+1 cycles when cw_ready is held at 1.
- Backpressure: in DONE with cw_ready=0, cw and cw_valid are held indefinitely. msg_ready=0, so msg is not sampled.
- msg is sampled only on the msg_valid && msg_ready edge; msg changes at other times are ignored.
- cw_valid never drops without a cw_ready handshake, except on rst.
- Arithmetic is GF(2) XOR only; no widths grow. The butterfly is one combinational XOR network indexed by the stage counter (LOG2N-bit counter, which wraps to 0 on leaving ENC).

Test Plan:
- Reset, then msg=8'h00 with msg_valid=1 and cw_ready=1 → cw_valid after 4 cycles, cw=16'h0000, msg_ready high again the following cycle.
- msg=8'h01 (u[7]=1) → cw=16'h00FF. msg=8'h80 (u[15]=1) → cw=16'hFFFF. msg=8'h81 → cw=16'hFF00.
- msg=8'h81 with cw_ready=0 for 10 cycles after cw_valid → cw=16'hFF00 and cw_valid held stable, msg_ready=0 throughout, a pending msg_valid is not consumed. Then cw_ready=1 → handshake completes in exactly one cycle.
- Back-to-back stream of 8'h01, 8'h80, 8'h81 with msg_valid and cw_ready tied high → codewords 16'h00FF, 16'hFFFF, 16'hFF00, one every 5 cycles, no IDLE cycle between frames.
- Assert rst in ENC at stage 2 → next cycle cw_valid=0, busy=0, msg_ready=1, cw=0. A following msg=8'h01 encodes to 16'h00FF.
- Random msgs (1000 frames) with random cw_ready stalls, compared against a reference model computing x_j = XOR over i of u_i for all i with (j & ~i)==0 → all codewords match, no message dropped or duplicated.
